// File: rtl/spi_mnrch_param.sv
// Parametrised SPI monarch, mode 3 (CPOL=1, CPHA=1), with busy flag and wrt-while-busy error pulse.
// Optional build macro SPI_LSB_FIRST_EN selects LSB-first shifting; MSB-first by default.
module spi_mnrch_param #(
   parameter int DATA_W = 16,
   parameter int DIV_W  = 5,
   parameter int NUM_SS = 1,
   localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wrt,
   input  logic [DATA_W-1:0] wt_data,
   input  logic [SEL_W-1:0]  ss_sel,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              busy,
   output logic              wrt_err,
   output logic [NUM_SS-1:0] SS_n,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [DIV_W-1:0] DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] DIV_FRONT = ~(DIV_ONE << (DIV_W-2));
   localparam logic [DIV_W-1:0] DIV_ALL   = {DIV_W{1'b1}};
   localparam logic [DIV_W-1:0] DIV_SMPL  = {1'b0, {(DIV_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W-1);

   typedef enum logic [1:0] {IDLE = 2'd0, FRONT = 2'd1, XFER = 2'd2, LAST = 2'd3} state_t;

   state_t            state_r;
   logic [DIV_W-1:0]  div_r;
   logic [DATA_W-1:0] sr_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              smpl_r;

   // Out-of-range selects decode to all ones so no serf is addressed.
   function automatic logic [NUM_SS-1:0] sel_decode(input logic [SEL_W-1:0] sel);
      logic [NUM_SS-1:0] r;
      r = {NUM_SS{1'b1}};
      for (int i = 0; i < NUM_SS; i++) begin
         r[i] = (sel != SEL_W'(i));
      end
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr, input logic b);
`ifdef SPI_LSB_FIRST_EN
      return {b, sr[DATA_W-1:1]};
`else
      return {sr[DATA_W-2:0], b};
`endif
   endfunction

`ifdef SPI_LSB_FIRST_EN
   assign MOSI = sr_r[0];
`else
   assign MOSI = sr_r[DATA_W-1];
`endif
   assign SCLK    = div_r[DIV_W-1];
   assign rd_data = sr_r;

   // Transaction sequencer, SCLK divider, shift register and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         div_r   <= DIV_FRONT;
         sr_r    <= {DATA_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         smpl_r  <= 1'b0;
         SS_n    <= {NUM_SS{1'b1}};
         done    <= 1'b0;
         busy    <= 1'b0;
         wrt_err <= 1'b0;
      end else begin
         wrt_err <= 1'b0;
         case (state_r)
            IDLE: begin
               div_r <= DIV_FRONT;
               if (wrt) begin
                  sr_r    <= wt_data;
                  cnt_r   <= {CNT_W{1'b0}};
                  done    <= 1'b0;
                  busy    <= 1'b1;
                  SS_n    <= sel_decode(ss_sel);
                  state_r <= FRONT;
               end
            end
            FRONT: begin
               wrt_err <= wrt;
               div_r   <= div_r + DIV_ONE;
               // Wrapping to zero here is the first SCLK fall; MOSI already holds bit one.
               if (div_r == DIV_ALL) begin
                  state_r <= XFER;
               end
            end
            XFER: begin
               wrt_err <= wrt;
               div_r   <= div_r + DIV_ONE;
               if (div_r == DIV_SMPL) begin
                  smpl_r <= MISO;
               end
               if (div_r == DIV_ALL) begin
                  sr_r  <= shift_in(sr_r, smpl_r);
                  cnt_r <= cnt_r + CNT_ONE;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= LAST;
               end
            end
            LAST: begin
               wrt_err <= wrt;
               if (div_r == DIV_SMPL) begin
                  smpl_r <= MISO;
               end
               // Reloading the front-porch value keeps SCLK high instead of a trailing fall.
               if (div_r == DIV_ALL) begin
                  sr_r    <= shift_in(sr_r, smpl_r);
                  div_r   <= DIV_FRONT;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  SS_n    <= {NUM_SS{1'b1}};
                  state_r <= IDLE;
               end else begin
                  div_r <= div_r + DIV_ONE;
               end
            end
            default: begin
               state_r <= IDLE;
               div_r   <= DIV_FRONT;
               SS_n    <= {NUM_SS{1'b1}};
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mnrch_param.sv
// Directed bench for spi_mnrch_param: default build, a 5-select build and a 12-bit/DIV_W=3 build.
module tb_spi_mnrch_param;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Default instance (16-bit, DIV_W=5, one select)
   logic        wrt0 = 1'b0;
   logic [15:0] wt0 = 16'h0000;
   logic [0:0]  sel0 = 1'b0;
   logic [15:0] rd0;
   logic        done0, busy0, err0, sclk0, mosi0, miso0;
   logic [0:0]  ssn0;
   logic        loop0 = 1'b1;
   logic        serf_bit = 1'b0;
   assign miso0 = loop0 ? mosi0 : serf_bit;

   // Five selects
   logic        wrt1 = 1'b0;
   logic [15:0] wt1 = 16'h0000;
   logic [2:0]  sel1 = 3'd0;
   logic [15:0] rd1;
   logic        done1, busy1, err1, sclk1, mosi1;
   logic [4:0]  ssn1;

   // 12-bit word, DIV_W=3
   logic        wrt2 = 1'b0;
   logic [11:0] wt2 = 12'h000;
   logic [0:0]  sel2 = 1'b0;
   logic [11:0] rd2;
   logic        done2, busy2, err2, sclk2, mosi2;
   logic [0:0]  ssn2;

   spi_mnrch_param u_dut0 (
      .clk(clk), .rst_n(rst_n), .wrt(wrt0), .wt_data(wt0), .ss_sel(sel0), .rd_data(rd0),
      .done(done0), .busy(busy0), .wrt_err(err0), .SS_n(ssn0), .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0));

   spi_mnrch_param #(.DATA_W(16), .DIV_W(5), .NUM_SS(5)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .wrt(wrt1), .wt_data(wt1), .ss_sel(sel1), .rd_data(rd1),
      .done(done1), .busy(busy1), .wrt_err(err1), .SS_n(ssn1), .SCLK(sclk1), .MOSI(mosi1), .MISO(mosi1));

   spi_mnrch_param #(.DATA_W(12), .DIV_W(3), .NUM_SS(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .wrt(wrt2), .wt_data(wt2), .ss_sel(sel2), .rd_data(rd2),
      .done(done2), .busy(busy2), .wrt_err(err2), .SS_n(ssn2), .SCLK(sclk2), .MOSI(mosi2), .MISO(mosi2));

   int vectors = 0;
   int errs = 0;
   int rise0 = 0, rise1 = 0, rise2 = 0, r_start = 0, sidx = 15;
   logic p0 = 1'b1, p1 = 1'b1, p2 = 1'b1;
   logic [15:0] cap0 = 16'h0000;
   logic [15:0] serf_word = 16'h0000;
   logic [4:0]  ss_and = 5'h1F, ss_or = 5'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clocks, sampling 1 time unit after each rising edge; also runs the serf model.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (sclk0 && !p0) begin
            rise0++;
            cap0 = {cap0[14:0], mosi0};
         end
         if (!sclk0 && p0 && !ssn0[0]) begin
            if (sidx >= 0) serf_bit = serf_word[sidx];
            sidx--;
         end
         p0 = sclk0;
         if (sclk1 && !p1) rise1++;
         p1 = sclk1;
         if (busy1) begin
            ss_and = ss_and & ssn1;
            ss_or  = ss_or | ssn1;
         end
         if (sclk2 && !p2) rise2++;
         p2 = sclk2;
      end
   endtask

   initial begin
      step(3);
      // Reset state
      chk("rst_ssn", ssn0, 1'b1);
      chk("rst_done", done0, 1'b0);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_err", err0, 1'b0);
      chk("rst_sclk", sclk0, 1'b1);
      chk("rst_ssn1", ssn1, 5'h1F);
      rst_n = 1'b1;
      step(2);

      // 1: loopback A5C3, done 9 + 16*32 = 521 clocks after the wrt edge
      r_start = rise0;
      wrt0 = 1'b1; wt0 = 16'hA5C3;
      step(1);
      wrt0 = 1'b0;
      chk("t1_ssn_low", ssn0, 1'b0);
      chk("t1_busy", busy0, 1'b1);
      step(520);
      chk("t1_done_early", done0, 1'b0);
      step(1);
      chk("t1_done", done0, 1'b1);
      chk("t1_ssn_high", ssn0, 1'b1);
      chk("t1_busy_end", busy0, 1'b0);
      chk("t1_rd", rd0, 16'hA5C3);
      chk("t1_rises", rise0 - r_start, 32'd16);

      // 2: serf returns 00E7 while master sends 8F00
      loop0 = 1'b0; serf_word = 16'h00E7; sidx = 15;
      step(2);
      chk("t2_sclk_idle_pre", sclk0, 1'b1);
      wrt0 = 1'b1; wt0 = 16'h8F00;
      step(1);
      wrt0 = 1'b0;
      chk("t2_done_clr", done0, 1'b0);
      step(521);
      chk("t2_done", done0, 1'b1);
      chk("t2_rd_lo", rd0[7:0], 8'hE7);
      chk("t2_rd", rd0, 16'h00E7);
      chk("t2_mosi", cap0, 16'h8F00);
      step(4);
      chk("t2_sclk_idle_post", sclk0, 1'b1);
      loop0 = 1'b1;

      // 3: five selects, ss_sel=2 then out-of-range 5
      ss_and = 5'h1F; ss_or = 5'h00; r_start = rise1;
      wrt1 = 1'b1; wt1 = 16'h3C3C; sel1 = 3'd2;
      step(1);
      wrt1 = 1'b0;
      chk("t3_ssn_sel2", ssn1, 5'b11011);
      step(521);
      chk("t3_done_a", done1, 1'b1);
      chk("t3_ss_and_a", ss_and, 5'b11011);
      chk("t3_ss_or_a", ss_or, 5'b11011);
      chk("t3_rd_a", rd1, 16'h3C3C);
      chk("t3_rises_a", rise1 - r_start, 32'd16);
      step(2);
      ss_and = 5'h1F; ss_or = 5'h00; r_start = rise1;
      wrt1 = 1'b1; wt1 = 16'h9E01; sel1 = 3'd5;
      step(1);
      wrt1 = 1'b0;
      chk("t3_busy_b", busy1, 1'b1);
      step(521);
      chk("t3_done_b", done1, 1'b1);
      chk("t3_ss_and_b", ss_and, 5'h1F);
      chk("t3_ss_or_b", ss_or, 5'h1F);
      chk("t3_rises_b", rise1 - r_start, 32'd16);
      chk("t3_err_b", err1, 1'b0);

      // 4: wrt while busy, wrt on the done cycle, wrt the cycle after done
      step(2);
      wrt0 = 1'b1; wt0 = 16'h3C5A;
      step(1);
      wrt0 = 1'b0;
      step(99);
      wrt0 = 1'b1; wt0 = 16'hFFFF;
      step(1);
      wrt0 = 1'b0;
      chk("t4_err_pulse", err0, 1'b1);
      chk("t4_busy_kept", busy0, 1'b1);
      step(1);
      chk("t4_err_clear", err0, 1'b0);
      step(419);
      wrt0 = 1'b1; wt0 = 16'h1234;
      step(1);
      chk("t4_done", done0, 1'b1);
      chk("t4_err_at_done", err0, 1'b1);
      chk("t4_rd_unchanged", rd0, 16'h3C5A);
      wt0 = 16'h6B6B;
      step(1);
      wrt0 = 1'b0;
      chk("t4_accept_busy", busy0, 1'b1);
      chk("t4_accept_done", done0, 1'b0);
      chk("t4_accept_err", err0, 1'b0);
      chk("t4_accept_ssn", ssn0, 1'b0);
      step(521);
      chk("t4_b2b_done", done0, 1'b1);
      chk("t4_b2b_rd", rd0, 16'h6B6B);

      // 5: 12-bit, DIV_W=3: done 3 + 12*8 = 99 clocks after the wrt edge
      step(2);
      r_start = rise2;
      wrt2 = 1'b1; wt2 = 12'h5A9;
      step(1);
      wrt2 = 1'b0;
      step(98);
      chk("t5_done_early", done2, 1'b0);
      step(1);
      chk("t5_done", done2, 1'b1);
      chk("t5_rd", rd2, 12'h5A9);
      chk("t5_rises", rise2 - r_start, 32'd12);
      chk("t5_ssn", ssn2, 1'b1);

      // 6: reset during bit 7, then a clean transaction
      step(2);
      wrt0 = 1'b1; wt0 = 16'hC3A5;
      step(1);
      wrt0 = 1'b0;
      step(243);
      chk("t6_busy_mid", busy0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ssn", ssn0, 1'b1);
      chk("t6_rst_busy", busy0, 1'b0);
      chk("t6_rst_done", done0, 1'b0);
      chk("t6_rst_sclk", sclk0, 1'b1);
      #1;
      rst_n = 1'b1;
      step(2);
      wrt0 = 1'b1; wt0 = 16'h1357;
      step(1);
      wrt0 = 1'b0;
      step(521);
      chk("t6_done", done0, 1'b1);
      chk("t6_rd", rd0, 16'h1357);
      chk("t6_err", err0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
